// File: rtl/mod_n_step_counter_if.sv
// Control/status bundle for mod_n_step_counter: the master drives the requests,
// the slave (the counter) returns Count and the Wrap/Err pulses.
interface mod_n_step_counter_if #(
   parameter int unsigned WIDTH = 4
) ();
   logic             Enable;
   logic [1:0]       Control;
   logic [WIDTH-1:0] Step;
   logic             Load;
   logic [WIDTH-1:0] LoadValue;
   logic [WIDTH-1:0] Count;
   logic             Wrap;
   logic             Err;

   modport master (
      output Enable, Control, Step, Load, LoadValue,
      input  Count, Wrap, Err
   );

   modport slave (
      input  Enable, Control, Step, Load, LoadValue,
      output Count, Wrap, Err
   );
endinterface

// File: rtl/mod_n_step_counter.sv
// Modulo-MODULUS counter with programmable step, load, clear and registered Wrap/Err pulses.
// Define MOD_COUNTER_SATURATE_EN to clamp at the range limits instead of wrapping.
module mod_n_step_counter #(
   parameter int unsigned MODULUS     = 9,
   parameter int unsigned RESET_VALUE = 0
) (
   input logic                  Clock,
   input logic                  Reset,
   mod_n_step_counter_if.slave  bus
);
   localparam int unsigned WIDTH = $clog2(MODULUS);
   localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VALUE);
   localparam logic [1:0] CTL_UP    = 2'b01;
   localparam logic [1:0] CTL_DOWN  = 2'b10;
   localparam logic [1:0] CTL_CLEAR = 2'b11;

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   dn_sum;
   logic             step_ok;

   // Arithmetic is carried at WIDTH+1 bits so neither sum can overflow.
   always_comb begin
      up_sum  = {1'b0, count_q} + {1'b0, bus.Step};
      dn_sum  = {1'b0, count_q} + MOD_W - {1'b0, bus.Step};
      step_ok = ({1'b0, bus.Step} < MOD_W);
   end

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (bus.Load) begin
         if ({1'b0, bus.LoadValue} < MOD_W) count_d = bus.LoadValue;
         else                               err_d   = 1'b0 | 1'b1;
      end else if (bus.Control == CTL_CLEAR) begin
         count_d = '0;
      end else if (bus.Enable && (bus.Control == CTL_UP || bus.Control == CTL_DOWN)) begin
         if (!step_ok) begin
            err_d = 1'b1;
         end else if (bus.Control == CTL_UP) begin
            if (up_sum >= MOD_W) begin
               wrap_d = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
               count_d = MAX_CNT;
`else
               count_d = WIDTH'(up_sum - MOD_W);
`endif
            end else begin
               count_d = WIDTH'(up_sum);
            end
         end else begin
            if (bus.Step > count_q) begin
               wrap_d = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
               count_d = '0;
`else
               count_d = WIDTH'(dn_sum);
`endif
            end else begin
               count_d = count_q - bus.Step;
            end
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         count_q <= RST_CNT;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   // MAX_CNT and dn_sum are only consumed by one of the two build variants.
   logic unused_ok;
   assign unused_ok = ^{MAX_CNT, dn_sum};

   assign bus.Count = count_q;
   assign bus.Wrap  = wrap_q;
   assign bus.Err   = err_q;
endmodule

// File: tb/tb_mod_n_step_counter.sv
// Bench for mod_n_step_counter (MODULUS=9): directed plan steps, then random traffic
// checked against an integer-arithmetic reference model.
module tb_mod_n_step_counter;
   localparam int M = 9;
`ifdef MOD_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset;
   int   vectors     = 0;
   int   miscompares = 0;
   int   m_count;
   logic m_wrap, m_err;

   always #5 Clock = ~Clock;

   mod_n_step_counter_if #(.WIDTH(4)) bus ();

   mod_n_step_counter #(.MODULUS(M), .RESET_VALUE(0)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: plain signed integer arithmetic on the requested result.
   task automatic model(input logic ld, input logic [3:0] lv, input logic en,
                        input logic [1:0] ctl, input logic [3:0] st);
      int req;
      m_wrap = 1'b0;
      m_err  = 1'b0;
      if (ld) begin
         if (int'(lv) < M) m_count = int'(lv);
         else              m_err = 1'b1;
      end else if (ctl == 2'd3) begin
         m_count = 0;
      end else if (en && (ctl == 2'd1 || ctl == 2'd2)) begin
         if (int'(st) >= M) begin
            m_err = 1'b1;
         end else begin
            req = (ctl == 2'd1) ? m_count + int'(st) : m_count - int'(st);
            if (req >= M || req < 0) begin
               m_wrap = 1'b1;
               if (SAT) m_count = (req < 0) ? 0 : M - 1;
               else     m_count = ((req % M) + M) % M;
            end else begin
               m_count = req;
            end
         end
      end
   endtask

   task automatic cycle(input string tag, input logic ld, input logic [3:0] lv, input logic en,
                        input logic [1:0] ctl, input logic [3:0] st);
      bus.Load      = ld;
      bus.LoadValue = lv;
      bus.Enable    = en;
      bus.Control   = ctl;
      bus.Step      = st;
      model(ld, lv, en, ctl, st);
      @(posedge Clock);
      #1;
      chk({tag, " count"}, 32'(bus.Count), 32'(m_count));
      chk({tag, " wrap"},  32'(bus.Wrap),  32'(m_wrap));
      chk({tag, " err"},   32'(bus.Err),   32'(m_err));
   endtask

   // Directed step: checked against the model and against hand-derived constants.
   task automatic dstep(input string tag, input logic ld, input logic [3:0] lv, input logic en,
                        input logic [1:0] ctl, input logic [3:0] st,
                        input int ec, input logic ew, input logic ee);
      cycle(tag, ld, lv, en, ctl, st);
      chk({tag, " count const"}, 32'(bus.Count), 32'(ec));
      chk({tag, " wrap const"},  32'(bus.Wrap),  32'(ew));
      chk({tag, " err const"},   32'(bus.Err),   32'(ee));
   endtask

   // Assert Reset between edges and check the asynchronous effect before the next edge.
   task automatic mid_reset(input string tag);
      #2 Reset = 1'b1;
      #1;
      m_count = 0;
      m_wrap  = 1'b0;
      m_err   = 1'b0;
      chk({tag, " count"}, 32'(bus.Count), 32'd0);
      chk({tag, " wrap"},  32'(bus.Wrap),  32'd0);
      chk({tag, " err"},   32'(bus.Err),   32'd0);
      #1 Reset = 1'b0;
   endtask

   initial begin
      logic       ld, en;
      logic [3:0] lv, st;
      logic [1:0] ctl;
      bus.Load = 1'b0; bus.LoadValue = '0; bus.Enable = 1'b0; bus.Control = 2'b00; bus.Step = '0;
      Reset = 1'b1;
      m_count = 0; m_wrap = 1'b0; m_err = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("reset count", 32'(bus.Count), 32'd0);
      chk("reset wrap",  32'(bus.Wrap),  32'd0);
      chk("reset err",   32'(bus.Err),   32'd0);
      Reset = 1'b0;

      // 1: async reset mid-operation, then counting resumes from 0
      dstep("t1 load5", 1, 4'd5, 0, 2'b00, 4'd0, 5, 0, 0);
      mid_reset("t1 midreset");
      dstep("t1 inc", 0, 4'd0, 1, 2'b01, 4'd1, 1, 0, 0);

      // 2: step-1 counting across the boundary
      dstep("t2 clear", 0, 4'd0, 0, 2'b11, 4'd0, 0, 0, 0);
      for (int i = 1; i <= 10; i++)
         dstep($sformatf("t2 inc%0d", i), 0, 4'd0, 1, 2'b01, 4'd1,
               SAT ? ((i > 8) ? 8 : i) : (i % 9), SAT ? (i > 8) : (i % 9 == 0), 0);

      // 3: larger steps upward
      dstep("t3 load7", 1, 4'd7, 0, 2'b00, 4'd0, 7, 0, 0);
      dstep("t3 7+2",   0, 4'd0, 1, 2'b01, 4'd2, SAT ? 8 : 0, 1, 0);
      dstep("t3 +2",    0, 4'd0, 1, 2'b01, 4'd2, SAT ? 8 : 2, SAT, 0);
      dstep("t3 load8", 1, 4'd8, 0, 2'b00, 4'd0, 8, 0, 0);
      dstep("t3 8+3",   0, 4'd0, 1, 2'b01, 4'd3, SAT ? 8 : 2, 1, 0);

      // 4: decrement with and without underflow
      dstep("t4 load0", 1, 4'd0, 0, 2'b00, 4'd0, 0, 0, 0);
      dstep("t4 0-1",   0, 4'd0, 1, 2'b10, 4'd1, SAT ? 0 : 8, 1, 0);
      dstep("t4 load1", 1, 4'd1, 0, 2'b00, 4'd0, 1, 0, 0);
      dstep("t4 1-3",   0, 4'd0, 1, 2'b10, 4'd3, SAT ? 0 : 7, 1, 0);
      dstep("t4 load5", 1, 4'd5, 0, 2'b00, 4'd0, 5, 0, 0);
      dstep("t4 5-2",   0, 4'd0, 1, 2'b10, 4'd2, 3, 0, 0);

      // 5: load priority, illegal load, clear without Enable
      dstep("t5 loadwins", 1, 4'd5,  1, 2'b01, 4'd1, 5, 0, 0);
      dstep("t5 badload",  1, 4'd12, 1, 2'b01, 4'd1, 5, 0, 1);
      dstep("t5 clear",    0, 4'd0,  0, 2'b11, 4'd1, 0, 0, 0);

      // 6: illegal step, zero step, disabled increment
      dstep("t6 load4",  1, 4'd4,  0, 2'b00, 4'd0, 4, 0, 0);
      dstep("t6 step9",  0, 4'd0,  1, 2'b01, 4'd9, 4, 0, 1);
      dstep("t6 step0",  0, 4'd0,  1, 2'b01, 4'd0, 4, 0, 0);
      dstep("t6 dec15",  0, 4'd0,  1, 2'b10, 4'd15, 4, 0, 1);
      dstep("t6 en0",    0, 4'd0,  0, 2'b01, 4'd3, 4, 0, 0);
      dstep("t6 hold",   0, 4'd0,  1, 2'b00, 4'd3, 4, 0, 0);
      dstep("t6 load7",  1, 4'd7,  0, 2'b00, 4'd0, 7, 0, 0);
      dstep("t6 7+2",    0, 4'd0,  1, 2'b01, 4'd2, SAT ? 8 : 0, 1, 0);
      dstep("t6 load1",  1, 4'd1,  0, 2'b00, 4'd0, 1, 0, 0);
      dstep("t6 1-3",    0, 4'd0,  1, 2'b10, 4'd3, SAT ? 0 : 7, 1, 0);

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         ld  = ($urandom_range(0, 9) == 0);
         lv  = 4'($urandom_range(0, 15));
         en  = ($urandom_range(0, 3) != 0);
         ctl = 2'($urandom_range(0, 3));
         st  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
         cycle($sformatf("rnd%0d", n), ld, lv, en, ctl, st);
         chk($sformatf("rnd%0d range", n), 32'(bus.Count < 4'(M)), 32'd1);
         if ($urandom_range(0, 39) == 0) mid_reset($sformatf("rnd%0d reset", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
